// File: rtl/pattern_sequencer_pkg.sv
// Shared state encoding and index-stepping helpers for the pattern sequencer.
package pattern_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2
  } state_e;

  // Next index for a step of a circular sequence of len entries.
  function automatic int unsigned idx_next(input int unsigned cur, input logic dir,
                                           input int unsigned len);
    if (dir) begin
      return (cur == 0) ? len - 1 : cur - 1;
    end
    return (cur == len - 1) ? 0 : cur + 1;
  endfunction

  function automatic logic idx_wraps(input int unsigned cur, input logic dir,
                                     input int unsigned len);
    return dir ? (cur == 0) : (cur == len - 1);
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running 2^DIV_N divider; tick is registered and follows the counter's zero state.
module tick_divider #(
  parameter int unsigned DIV_N = 25
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  logic [DIV_N-1:0] cnt_q;
  logic             tick_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_q + DIV_N'(1);
      tick_q <= (cnt_q == '0);
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/pattern_sequencer.sv
// Steps through a loadable table of segment patterns on each divider tick.
// Define PATSEQ_BLANK_EN to insert a blank (all-ones) phase between patterns.
module pattern_sequencer
  import pattern_sequencer_pkg::*;
#(
  parameter int unsigned DIV_N   = 25,
  parameter int unsigned DISP_W  = 14,
  parameter int unsigned PAT_LEN = 16,
  localparam int unsigned IDX_W  = $clog2(PAT_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              dir,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [IDX_W-1:0]  ld_addr,
  input  logic [DISP_W-1:0] ld_data,
  output logic [DISP_W-1:0] disp,
  output logic [IDX_W-1:0]  idx,
  output logic              wrap
);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                phase_q, phase_d;
  logic                wrap_q, wrap_d;
  logic [DISP_W-1:0]   disp_q, disp_d;
  logic [DISP_W-1:0]   pat_q [PAT_LEN];

  logic                tick;
  logic                step;
  logic                advance;
  logic                ld_hit;
  logic [DISP_W-1:0]   pat_show;

  tick_divider #(
    .DIV_N(DIV_N)
  ) u_tick_divider (
    .clk   (clk),
    .rst   (rst),
    .tick_o(tick)
  );

  assign ld_ready = (state_q != StRun);
  // Out-of-range addresses complete the handshake but never touch the table.
  assign ld_hit   = ld_valid && ld_ready && (32'(ld_addr) < PAT_LEN);
  assign pat_show = phase_q ? '1 : ~pat_q[idx_q];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    wrap_d  = 1'b0;
    disp_d  = disp_q;
    step    = 1'b0;
    advance = 1'b0;

    unique case (state_q)
      StIdle: begin
        disp_d = '1;
        if (run) state_d = StRun;
      end
      StRun: begin
        disp_d = pat_show;
        if (!run) begin
          state_d = StPause;
        end else if (tick) begin
          step = 1'b1;
        end
      end
      StPause: begin
        if (ld_hit && (ld_addr == idx_q)) disp_d = phase_q ? '1 : ~ld_data;
        if (run) state_d = StRun;
      end
      default: state_d = StIdle;
    endcase

`ifdef PATSEQ_BLANK_EN
    advance = step && phase_q;
    if (step) phase_d = ~phase_q;
`else
    advance = step;
`endif

    if (advance) begin
      idx_d  = IDX_W'(idx_next(32'(idx_q), dir, PAT_LEN));
      wrap_d = idx_wraps(32'(idx_q), dir, PAT_LEN);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      phase_q <= 1'b0;
      wrap_q  <= 1'b0;
      disp_q  <= '1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      wrap_q  <= wrap_d;
      disp_q  <= disp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(PAT_LEN); i++) pat_q[i] <= '0;
    end else if (ld_hit) begin
      pat_q[ld_addr] <= ld_data;
    end
  end

  assign disp = disp_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule
